// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider for the EX stage.
//
// EX holds start_i high (stalling) until ready_o rises, then drops start_i.
// Unsigned (DIVU) and signed (DIV) division are supported. The result is
// returned as {remainder, quotient}, which EX writes to HI/LO.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = signed division, 0 = unsigned (sampled with start)
//   opdata1_i    dividend (sampled with start)
//   opdata2_i    divisor  (sampled with start)
//   start_i      request, held high until ready_o is seen
//   annul_i      abort the current operation (pipeline flush)
//   result_o     [2*WIDTH-1:WIDTH] remainder, [WIDTH-1:0] quotient
//   ready_o      result valid
//
// Timing: ready_o goes high WIDTH edges after the start-sampling edge,
// i.e. WIDTH+1 cycles counting that edge. A divisor of zero produces a zero
// result one cycle after start. One ready_o window is produced per accepted
// start; it is held while start_i stays high.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dvsr_q;     // divisor magnitude
  logic             neg_quo_q;  // quotient must be negated at the end
  logic             neg_rem_q;  // remainder must be negated at the end

  // Two's-complement negation when requested; wraps modulo 2^WIDTH, so the
  // most negative dividend divided by -1 yields itself.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Operand magnitudes taken at start.
  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_abs, op2_abs;

  always_comb begin
    op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    op1_abs = neg_if(opdata1_i, op1_neg);
    op2_abs = neg_if(opdata2_i, op2_neg);
  end

  // One restoring iteration: shift in the next dividend bit and try to
  // subtract the divisor. The trial is WIDTH+1 bits wide so the shifted
  // remainder never overflows and the sign bit decides restore/commit.
  logic signed [WIDTH:0] trial;
  logic [WIDTH-1:0]      rem_next, quo_next;
  logic                  last_iter;

  always_comb begin
    trial     = $signed({rem_q, quo_q[WIDTH-1]}) - $signed({1'b0, dvsr_q});
    rem_next  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_next  = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next    = trial[WIDTH-1:0];
      quo_next[0] = 1'b1;
    end
    last_iter = (cnt_q == LAST_CNT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!annul_i && start_i) begin
          state_d = (opdata2_i == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (annul_i)        state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE: begin
        if (annul_i || !start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (!annul_i && start_i) begin
            if (opdata2_i == '0) begin
              ready_o <= 1'b1;
            end else begin
              neg_quo_q <= op1_neg ^ op2_neg;
              neg_rem_q <= op1_neg;
              quo_q     <= op1_abs;
              dvsr_q    <= op2_abs;
              rem_q     <= '0;
              cnt_q     <= '0;
            end
          end
        end
        BUSY: begin
          if (annul_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              ready_o  <= 1'b1;
              result_o <= {neg_if(rem_next, neg_rem_q),
                           neg_if(quo_next, neg_quo_q)};
            end
          end
        end
        DONE: begin
          if (annul_i || !start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: directed operations with hand-computed results.
// The driver pushes each expected {remainder, quotient} into a queue when it
// issues a start; an independent monitor pops and compares on each rising
// edge of ready_o. The driver additionally checks latency, hold behaviour,
// clearing, annul and reset.
module tb_iter_divider;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [2*W-1:0] exp_q[$];

  iter_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
    end
  endtask

  // Monitor: compare the result on every rising edge of ready_o.
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (ready_o === 1'b1 && !rdy_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: got result 0x%h, expected no ready", result_o);
      end else begin
        check("scoreboard_result", result_o, exp_q.pop_front());
      end
    end
    rdy_prev = (ready_o === 1'b1);
  end

  // Issue one operation, check latency, hold while start stays high, then
  // drop start and check the outputs clear. Called just after a posedge.
  task automatic run_op(input string name, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int exp_lat,
                        input int hold, input logic chg);
    int lat;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(exp);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_o === 1'b1) break;
      if (chg && lat == 5) begin
        opdata1_i    = 32'h1234_5678;
        opdata2_i    = 32'h0000_0003;
        signed_div_i = ~sgn;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold"}, {result_o[2*W-2:0], ready_o}, {exp[2*W-2:0], 1'b1});
    end
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_clear"}, {63'(result_o), ready_o}, 64'd0);
  endtask

  initial begin
    int rdy_cnt;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {63'(result_o), ready_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Main function.
    run_op("u_7_2",    1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 33, 1, 1'b0);
    run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 0, 1'b0);
    run_op("s_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 33, 0, 1'b0);
    run_op("s_m7_m2",  1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFFFFFF_00000003, 33, 0, 1'b0);
    run_op("u_m7_2",   1'b0, 32'hFFFF_FFF9,  32'd2,          64'h00000001_7FFFFFFC, 33, 0, 1'b0);

    // Boundaries.
    run_op("s_min_m1", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 33, 0, 1'b0);
    run_op("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 33, 0, 1'b0);
    run_op("u_5_9",    1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 33, 0, 1'b0);
    run_op("u_max_max",1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001, 33, 0, 1'b0);

    // Divide by zero: one-cycle latency, held for 3 cycles.
    run_op("div0",     1'b1, 32'd1234,       32'd0,          64'd0,                  1, 3, 1'b0);

    // Operand changes while busy are ignored.
    run_op("chg_busy", 1'b0, 32'd1000,       32'd7,          64'h00000006_0000008E, 33, 0, 1'b1);

    // Annul at busy cycle 10: no ready window must appear.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      if (ready_o !== 1'b0) rdy_cnt++;
      @(posedge clk);
      #1;
    end
    check("annul_no_ready", 64'(rdy_cnt), 64'd0);
    run_op("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0, 1'b0);

    // Reset at busy cycle 20.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd12345;
    opdata2_i    = 32'd67;
    start_i      = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_op", {63'(result_o), ready_o}, 64'd0);
    rst = 1'b0;
    run_op("after_reset", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0, 1'b0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider serving the EX stage through a start/ready handshake.
- EX holds start_i high and stalls the pipeline until ready_o rises, then drops start_i.
- The divider returns {remainder, quotient} as HI/LO for DIV/DIVU.
- Supports signed and unsigned 32-bit division and annulment from pipeline flush.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high; clock clk.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  WIDTH  dividend; sampled with start.
- opdata2_i  input  WIDTH  divisor; sampled with start.
- start_i  input  1  request; held high by EX until ready_o is seen.
- annul_i  input  1  abort current operation.
- result_o  output  2*WIDTH  [63:32] remainder (HI), [31:0] quotient (LO); valid only while ready_o=1.
- ready_o  output  1  result valid.

Behaviour:
- All outputs are registered. On rst: state IDLE, ready_o=0, result_o=0, counter=0, internal registers cleared.
- Reset mid-operation discards all state and returns to IDLE.
- States are IDLE, BUSY, DONE.
- IDLE
  - If annul_i=1, stay IDLE; annul has priority over start.
  - Else if start_i=1 and opdata2_i=0, go to DONE with ready_o<=1 and result_o<=0 (divide-by-zero; 1-cycle latency).
  - Else if start_i=1, latch sign flags (dividend sign, divisor sign, signed_div_i).
  - On that start, latch absolute values: two's-complement negate an operand if signed_div_i and its MSB is 1.
  - On that start, clear the partial remainder and counter=0, and go to BUSY.
- BUSY (one iteration per cycle)
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - Trial subtract the divisor in WIDTH+1 bits.
  - If non-negative: commit and set the quotient LSB=1; else restore and set LSB=0.
  - Counter increments once per iteration. The iteration with counter==WIDTH-1 is the last one.
  - On the last iteration, go to DONE and register the sign-corrected result with ready_o<=1.
  - ready_o is therefore first high in the cycle after the WIDTH-th BUSY edge, i.e. WIDTH+1 cycles after the start-sampling edge (33 for WIDTH=32).
  - Input changes while BUSY are ignored; start_i dropping in BUSY does not abort.
  - annul_i=1 in BUSY: go to IDLE next edge, ready_o stays 0, result_o=0.
- Sign correction (signed mode only)
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^WIDTH: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Unsigned mode: no correction.
- DONE
  - ready_o=1 and result_o are held stable while start_i=1.
  - When start_i=0 or annul_i=1: next edge goes to IDLE with ready_o<=0 and result_o<=0.
  - A new start cannot be accepted in the same cycle as leaving DONE; it must first be seen in IDLE.
- Exactly one ready_o pulse window per accepted start; never asserted while BUSY.

Test Plan:
- Unsigned: start=1, signed=0, opdata1=7, opdata2=2 → ready_o rises 33 cycles after the start edge with result_o=0x00000001_00000003. Drop start → ready_o=0, result_o=0 one cycle later.
- Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2 → result_o=0xFFFFFFFF_FFFFFFFD. Also opdata1=7, opdata2=0xFFFFFFFE → result_o=0x00000001_FFFFFFFD.
- Boundaries, all after 33 cycles:
  - Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
  - Unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
  - Unsigned 5 / 9 → 0x00000005_00000000.
- Divide-by-zero: opdata2=0, start=1 → ready_o=1 the next cycle with result_o=0; ready_o holds while start stays high for 3 cycles, then clears after start drops.
- Annul and stability:
  - Assert annul_i for 1 cycle at BUSY cycle 10 → ready_o never rises; a new start of 100/7 is then accepted and yields 0x00000002_0000000E.
  - Change opdata1/2 during BUSY → result is unaffected.
- Reset: assert rst at BUSY cycle 20 → next cycle ready_o=0, result_o=0. A subsequent 9/3 start completes normally with 0x00000000_00000003.
